// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the MEM/WB forwarding-source slice.
//   - default datapath / register-index widths
//   - base opcode constants used by the decode side of the pipeline
//   - state encoding of the data-memory handshake FSM
//   - small helper to classify an instruction as a memory access
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [6:0] OP_IMME_ARITHMETIC   = 7'b0010011;
  localparam logic [6:0] OP_ARITHMETIC        = 7'b0110011;
  localparam logic [6:0] OP_CONDITIONAL_JMP   = 7'b1100011;
  localparam logic [6:0] OP_UNCONDITIONAL_JMP = 7'b1101111;
  localparam logic [6:0] OP_MEMORY_LOAD       = 7'b0000011;
  localparam logic [6:0] OP_MEMORY_STORE      = 7'b0100011;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  function automatic logic is_mem_op(input logic memtoreg, input logic memwrite);
    return memtoreg | memwrite;
  endfunction

endpackage

// File: rtl/mem_wb_forward_source_dmem_handshake.sv
// -----------------------------------------------------------------------------
// dmem_handshake
// Request/acknowledge sequencer for the data-memory port, with a timeout
// watchdog and a sticky error flag.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | EX_MEM holds an ALU op or a bubble; no request outstanding
//   ACCESS | EX_MEM holds a load/store; request held until ack or timeout
//
// Ports
//   clk, rst_n  : clock, async active-low reset
//   start       : a memory op is being captured into EX_MEM this edge
//   ack         : memory completion pulse
//   access      : FSM is in ACCESS (drives dmem_req)
//   busy        : ACCESS and no ack this cycle (upstream must hold)
//   done        : ACCESS and ack this cycle (access retires at this edge)
//   abort       : busy cycle in which the timeout expires
//   mem_error   : sticky timeout flag
// -----------------------------------------------------------------------------
module dmem_handshake
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ack,
  output logic access,
  output logic busy,
  output logic done,
  output logic abort,
  output logic mem_error
);

  // The count reaches MEM_TIMEOUT at the edge that closes the last allowed
  // busy cycle, so the compare is against MEM_TIMEOUT-1 before that edge.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  mem_state_e      state_q;
  mem_state_e      state_d;
  logic [TO_W-1:0] to_cnt_q;

  assign access = (state_q == ACCESS);
  assign busy   = access & ~ack;
  assign done   = access & ack;
  // busy already excludes ack, so an ack in the expiring cycle wins.
  assign abort  = busy & (to_cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (start) state_d = ACCESS;
    end else begin
      if (done) begin
        // back-to-back memory ops stay in ACCESS
        state_d = start ? ACCESS : IDLE;
      end else if (abort) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (start) begin
      to_cnt_q <= '0;
    end else if (busy) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_error <= 1'b0;
    end else if (abort) begin
      mem_error <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_wb_forward_source.sv
// -----------------------------------------------------------------------------
// mem_wb_forward_source
// Producer end of the EX-stage forwarding path. Holds the EX/MEM and MEM/WB
// pipeline registers, runs loads/stores through the dmem req/ack port and
// exposes the rd/regwrite/result/memtoreg values the hazard checker uses.
//
// Ports
//   clk, rst_n         : clock, async active-low reset
//   ex_*               : instruction leaving EX (rd, write enable, load/store
//                        markers, ALU result/address, store data)
//   ex_stall           : load-use stall; a bubble is captured instead
//   dmem_req/we/addr/wdata, dmem_ack/rdata : data-memory handshake
//   EX_MEM_*           : forwarding source 1
//   MEM_WB_*           : forwarding source 2 / writeback
//   mem_busy           : upstream must hold PC, IF/ID and ID/EX
//   mem_error          : sticky memory timeout flag
// -----------------------------------------------------------------------------
module mem_wb_forward_source
  import pipeline_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memtoreg,
  input  logic              ex_memwrite,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic              ex_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [REG_AW-1:0] EX_MEM_rd,
  output logic              EX_MEM_regwrite,
  output logic [XLEN-1:0]   EX_MEM_ALU_result,
  output logic              EX_MEM_memtoreg,
  output logic [REG_AW-1:0] MEM_WB_rd,
  output logic [XLEN-1:0]   MEM_WB_result,
  output logic              MEM_WB_regwrite,
  output logic              mem_busy,
  output logic              mem_error
);

  logic            em_memwrite_q;
  logic [XLEN-1:0] em_store_data_q;

  logic access;
  logic busy;
  logic done;
  logic abort;
  logic capture;
  logic start;

  assign capture  = ~busy;
  assign start    = capture & ~ex_stall & is_mem_op(ex_memtoreg, ex_memwrite);
  assign mem_busy = busy;

  dmem_handshake #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_hs (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ack       (dmem_ack),
    .access    (access),
    .busy      (busy),
    .done      (done),
    .abort     (abort),
    .mem_error (mem_error)
  );

  // Address/data come straight from EX_MEM, which cannot change while the
  // access is busy, so the request stays stable until the ack.
  assign dmem_req   = access;
  assign dmem_we    = access & em_memwrite_q;
  assign dmem_addr  = access ? EX_MEM_ALU_result : '0;
  assign dmem_wdata = access ? em_store_data_q   : '0;

  // EX/MEM register. An aborted access is flushed to a bubble so the
  // forwarding checker never sees a stale address as a forwardable result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      EX_MEM_rd         <= '0;
      EX_MEM_regwrite   <= 1'b0;
      EX_MEM_memtoreg   <= 1'b0;
      EX_MEM_ALU_result <= '0;
      em_memwrite_q     <= 1'b0;
      em_store_data_q   <= '0;
    end else if (abort || (capture && ex_stall)) begin
      EX_MEM_rd         <= '0;
      EX_MEM_regwrite   <= 1'b0;
      EX_MEM_memtoreg   <= 1'b0;
      EX_MEM_ALU_result <= '0;
      em_memwrite_q     <= 1'b0;
      em_store_data_q   <= '0;
    end else if (capture) begin
      EX_MEM_rd         <= ex_rd;
      // x0 is never forwarded or written back
      EX_MEM_regwrite   <= ex_regwrite & (ex_rd != '0);
      EX_MEM_memtoreg   <= ex_memtoreg;
      EX_MEM_ALU_result <= ex_alu_result;
      em_memwrite_q     <= ex_memwrite;
      em_store_data_q   <= ex_store_data;
    end
  end

  // MEM/WB register. Busy cycles (including the abort cycle) write a bubble
  // so a retiring result is written back exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MEM_WB_rd       <= '0;
      MEM_WB_result   <= '0;
      MEM_WB_regwrite <= 1'b0;
    end else if (busy) begin
      MEM_WB_regwrite <= 1'b0;
    end else begin
      MEM_WB_rd       <= EX_MEM_rd;
      MEM_WB_result   <= (done && EX_MEM_memtoreg) ? dmem_rdata : EX_MEM_ALU_result;
      MEM_WB_regwrite <= EX_MEM_regwrite & ~em_memwrite_q;
    end
  end

endmodule

// File: tb/tb_mem_wb_forward_source.sv
module tb_mem_wb_forward_source;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int TMO    = 4;

  logic              clk;
  logic              rst_n;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memtoreg;
  logic              ex_memwrite;
  logic [XLEN-1:0]   ex_alu_result;
  logic [XLEN-1:0]   ex_store_data;
  logic              ex_stall;
  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic              dmem_ack;
  logic [XLEN-1:0]   dmem_rdata;
  logic [REG_AW-1:0] EX_MEM_rd;
  logic              EX_MEM_regwrite;
  logic [XLEN-1:0]   EX_MEM_ALU_result;
  logic              EX_MEM_memtoreg;
  logic [REG_AW-1:0] MEM_WB_rd;
  logic [XLEN-1:0]   MEM_WB_result;
  logic              MEM_WB_regwrite;
  logic              mem_busy;
  logic              mem_error;

  mem_wb_forward_source #(
    .XLEN(XLEN), .REG_AW(REG_AW), .MEM_TIMEOUT(TMO), .TO_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_memwrite(ex_memwrite), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_stall(ex_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_regwrite(EX_MEM_regwrite),
    .EX_MEM_ALU_result(EX_MEM_ALU_result), .EX_MEM_memtoreg(EX_MEM_memtoreg),
    .MEM_WB_rd(MEM_WB_rd), .MEM_WB_result(MEM_WB_result),
    .MEM_WB_regwrite(MEM_WB_regwrite), .mem_busy(mem_busy), .mem_error(mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (instruction-level view) ----------------
  logic [REG_AW-1:0] m_rd;
  logic              m_rw, m_m2r, m_mw;
  logic [XLEN-1:0]   m_res, m_sd;
  logic [REG_AW-1:0] w_rd;
  logic [XLEN-1:0]   w_res;
  logic              w_rw;
  logic              m_acc;
  int                m_waited;
  logic              m_err;

  task automatic model_bubble();
    m_rd = '0; m_rw = 0; m_m2r = 0; m_mw = 0; m_res = '0; m_sd = '0;
  endtask

  task automatic model_reset();
    model_bubble();
    w_rd = '0; w_res = '0; w_rw = 0;
    m_acc = 0; m_waited = 0; m_err = 0;
  endtask

  task automatic model_capture();
    if (ex_stall) begin
      model_bubble();
    end else begin
      m_rd = ex_rd; m_rw = ex_regwrite && (ex_rd != 0);
      m_m2r = ex_memtoreg; m_mw = ex_memwrite;
      m_res = ex_alu_result; m_sd = ex_store_data;
    end
    m_acc = m_m2r || m_mw;
    m_waited = 0;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_next();
    if (m_acc && dmem_ack) begin
      w_rd = m_rd; w_res = m_m2r ? dmem_rdata : m_res; w_rw = m_rw && !m_mw;
      model_capture();
    end else if (m_acc) begin
      m_waited++;
      w_rw = 0;
      if (m_waited == TMO) begin
        m_err = 1; m_acc = 0; model_bubble();
      end
    end else begin
      w_rd = m_rd; w_res = m_res; w_rw = m_rw;
      model_capture();
    end
  endtask

  task automatic model_check();
    check("mem_busy",     mem_busy,     m_acc && !dmem_ack);
    check("dmem_req",     dmem_req,     m_acc);
    check("dmem_we",      dmem_we,      m_acc && m_mw);
    check("dmem_addr",    dmem_addr,    m_acc ? m_res : '0);
    check("dmem_wdata",   dmem_wdata,   m_acc ? m_sd  : '0);
    check("em_rd",        EX_MEM_rd,        m_rd);
    check("em_regwrite",  EX_MEM_regwrite,  m_rw);
    check("em_result",    EX_MEM_ALU_result, m_res);
    check("em_memtoreg",  EX_MEM_memtoreg,  m_m2r);
    check("wb_rd",        MEM_WB_rd,        w_rd);
    check("wb_result",    MEM_WB_result,    w_res);
    check("wb_regwrite",  MEM_WB_regwrite,  w_rw);
    check("mem_error",    mem_error,        m_err);
  endtask

  // Called at a falling edge with inputs already applied; returns at the
  // next falling edge.
  task automatic step();
    #1;
    model_check();
    model_next();
    @(negedge clk);
  endtask

  task automatic set_ex(input logic [REG_AW-1:0] rd, input logic rw, input logic m2r,
                        input logic mw, input logic [XLEN-1:0] res,
                        input logic [XLEN-1:0] sd, input logic stall);
    ex_rd = rd; ex_regwrite = rw; ex_memtoreg = m2r; ex_memwrite = mw;
    ex_alu_result = res; ex_store_data = sd; ex_stall = stall;
  endtask

  task automatic set_bubble();
    set_ex('0, 0, 0, 0, '0, '0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   dmem_req, 0);
    check({tag, "_we"},    dmem_we, 0);
    check({tag, "_addr"},  dmem_addr, 0);
    check({tag, "_wdata"}, dmem_wdata, 0);
    check({tag, "_em"},    {EX_MEM_rd, EX_MEM_regwrite, EX_MEM_memtoreg, EX_MEM_ALU_result}, 0);
    check({tag, "_wb"},    {MEM_WB_rd, MEM_WB_regwrite, MEM_WB_result}, 0);
    check({tag, "_busy"},  mem_busy, 0);
    check({tag, "_err"},   mem_error, 0);
  endtask

  typedef struct {
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic [XLEN-1:0]   res;
    logic              stall;
    logic [REG_AW-1:0] exp_em_rd;
    logic              exp_em_rw;
    logic [XLEN-1:0]   exp_wb_res;
    logic              exp_wb_rw;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{5'd5,  1'b1, 32'h0000_1234, 1'b0, 5'd5,  1'b1, 32'h0000_1234, 1'b1};
    vecs[1] = '{5'd9,  1'b1, 32'h0000_AAAA, 1'b1, 5'd0,  1'b0, 32'h0000_0000, 1'b0};
    vecs[2] = '{5'd0,  1'b1, 32'hFFFF_FFFF, 1'b0, 5'd0,  1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{5'd31, 1'b0, 32'h0000_0055, 1'b0, 5'd31, 1'b0, 32'h0000_0055, 1'b0};
    vecs[4] = '{5'd12, 1'b1, 32'h8000_0001, 1'b0, 5'd12, 1'b1, 32'h8000_0001, 1'b1};

    rst_n = 0; dmem_ack = 0; dmem_rdata = '0;
    set_bubble();
    #12;
    check_all_zero("reset");
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // ---- table-driven non-memory ops ----
    foreach (vecs[i]) begin
      set_ex(vecs[i].rd, vecs[i].rw, 0, 0, vecs[i].res, 32'h0, vecs[i].stall);
      step();
      check($sformatf("vec%0d_em_rd", i), EX_MEM_rd, vecs[i].exp_em_rd);
      check($sformatf("vec%0d_em_rw", i), EX_MEM_regwrite, vecs[i].exp_em_rw);
      check($sformatf("vec%0d_req", i), dmem_req, 0);
      set_bubble();
      step();
      check($sformatf("vec%0d_wb_res", i), MEM_WB_result, vecs[i].exp_wb_res);
      check($sformatf("vec%0d_wb_rw", i), MEM_WB_regwrite, vecs[i].exp_wb_rw);
    end

    // ---- load with three wait cycles; ack lands as the timeout expires ----
    set_ex(5'd7, 1, 1, 0, 32'h0000_0100, 32'h0, 0);
    step();
    set_ex(5'd3, 1, 0, 0, 32'h0000_0077, 32'h0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("ld_req", dmem_req, 1);
      check("ld_addr", dmem_addr, 32'h100);
      check("ld_busy", mem_busy, 1);
      check("ld_wb_rw_wait", MEM_WB_regwrite, 0);
      check("ld_em_m2r", EX_MEM_memtoreg, 1);
      step();
    end
    dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    check("ld_busy_ack", mem_busy, 0);
    step();
    dmem_ack = 0;
    check("ld_wb_rd", MEM_WB_rd, 7);
    check("ld_wb_res", MEM_WB_result, 32'hDEAD_BEEF);
    check("ld_wb_rw", MEM_WB_regwrite, 1);
    check("ld_next_em_rd", EX_MEM_rd, 3);
    check("ld_no_err", mem_error, 0);
    set_bubble();
    step();
    check("ld_next_wb_res", MEM_WB_result, 32'h77);

    // ---- store that never gets an ack ----
    set_ex(5'd0, 0, 0, 1, 32'h0000_0200, 32'h0000_CAFE, 0);
    step();
    set_ex(5'd4, 1, 0, 0, 32'h0000_0044, 32'h0, 0);
    for (int c = 0; c < TMO; c++) begin
      #1;
      check("to_req", dmem_req, 1);
      check("to_we", dmem_we, 1);
      check("to_wdata", dmem_wdata, 32'hCAFE);
      step();
    end
    check("to_req_low", dmem_req, 0);
    check("to_err", mem_error, 1);
    check("to_busy_low", mem_busy, 0);
    check("to_wb_rw", MEM_WB_regwrite, 0);
    step();
    check("to_next_em_rd", EX_MEM_rd, 4);
    set_bubble();
    step();
    check("to_next_wb_res", MEM_WB_result, 32'h44);
    check("to_next_wb_rw", MEM_WB_regwrite, 1);
    check("to_err_sticky", mem_error, 1);

    // ---- reset in the middle of an access ----
    set_ex(5'd8, 1, 1, 0, 32'h0000_0300, 32'h0, 0);
    step();
    set_bubble();
    #2;
    check("rst_pre_req", dmem_req, 1);
    rst_n = 0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1;
    model_reset();
    dmem_ack = 1; dmem_rdata = 32'h1111_1111;
    step();
    dmem_ack = 0;
    check("rst_late_ack_rw", MEM_WB_regwrite, 0);
    step();
    check("rst_late_ack_rw2", MEM_WB_regwrite, 0);
    check("rst_late_ack_res", MEM_WB_result, 0);

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 500; n++) begin
      int kind;
      kind = int'($urandom_range(0, 5));
      set_ex(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             kind == 3, kind == 4, $urandom, $urandom,
             $urandom_range(0, 7) == 0);
      if (kind == 5) ex_rd = '0;
      dmem_ack   = m_acc ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
      dmem_rdata = $urandom;
      step();
    end
    dmem_ack = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_forward_source.md
Name: mem_wb_forward_source

Overview:
- Producer end of the EX-stage forwarding path.
- Owns the EX/MEM and MEM/WB pipeline registers and runs the data-memory access through a req/ack handshake.
- Drives the rd/regwrite/result/memtoreg signals that the EX-stage hazard checker consumes.
- Converts the checker's load-use stall into a bubble and back-pressures upstream while memory is busy.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register index width.
- MEM_TIMEOUT, 16, max cycles to wait for dmem_ack before aborting (≥2).
- TO_W, 5, timeout counter width; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_rd  in  REG_AW  destination register from EX
- ex_regwrite  in  1  EX instruction writes rd
- ex_memtoreg  in  1  EX instruction is a load
- ex_memwrite  in  1  EX instruction is a store
- ex_alu_result  in  XLEN  ALU result / memory address
- ex_store_data  in  XLEN  store data (already forwarded)
- ex_stall  in  1  load-use stall from hazard checker; insert bubble
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  XLEN  memory address
- dmem_wdata  out  XLEN  store data
- dmem_ack  in  1  memory completion, one-cycle pulse
- dmem_rdata  in  XLEN  load data, valid with dmem_ack
- EX_MEM_rd  out  REG_AW  forwarding source 1: rd
- EX_MEM_regwrite  out  1  forwarding source 1: write enable
- EX_MEM_ALU_result  out  XLEN  forwarding source 1: data
- EX_MEM_memtoreg  out  1  forwarding source 1: load marker
- MEM_WB_rd  out  REG_AW  forwarding source 2 / writeback rd
- MEM_WB_result  out  XLEN  ALU result or load data
- MEM_WB_regwrite  out  1  writeback enable
- mem_busy  out  1  upstream must hold PC, IF/ID and ID/EX
- mem_error  out  1  sticky timeout flag

Behaviour:
- Reset (rst_n low, async):
  - all EX_MEM_*, MEM_WB_*, dmem_* outputs, mem_error and the timeout counter go to 0
  - FSM goes to IDLE
  - an in-flight access is dropped; the pending ack is ignored after reset.
- FSM states:
  - IDLE: EX_MEM holds an ALU op or a bubble.
  - ACCESS: EX_MEM holds a load or store awaiting ack.
- EX_MEM capture, on each edge where mem_busy=0:
  - ex_stall=1 → bubble: rd=0, regwrite=0, memtoreg=0, memwrite=0, result=0.
  - Otherwise capture ex_*, with regwrite forced to 0 when ex_rd=0 (x0 never forwarded or written).
  - If captured memtoreg|memwrite → next state ACCESS, else IDLE.
- ACCESS:
  - dmem_req=1; dmem_we=memwrite; dmem_addr=EX_MEM_ALU_result; dmem_wdata = stored store data.
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are stable until the ack.
  - mem_busy = ACCESS & ~dmem_ack (combinational). No new capture while busy.
- Ack at edge k:
  - MEM_WB ← {EX_MEM_rd, load ? dmem_rdata : EX_MEM_ALU_result, EX_MEM_regwrite}. Stores have regwrite=0.
  - EX_MEM captures the next instruction at the same edge.
  - dmem_req deasserts unless the new capture is itself a memory op; back-to-back accesses are legal.
- dmem_ack while in IDLE is ignored.
- Non-memory op latency: ex_* at edge N → EX_MEM valid after N → MEM_WB valid after N+1.
- While mem_busy=1: MEM_WB_regwrite is driven 0 each cycle (bubble), so a result is never written back twice.
- Timeout counter:
  - clears on entry to ACCESS and increments each busy cycle.
  - On reaching MEM_TIMEOUT without ack: set mem_error (sticky until reset), retire the access as a bubble (MEM_WB_regwrite=0), deassert dmem_req, return to capture.
- Simultaneous ack and timeout in the same cycle: ack wins, no error.
- EX_MEM_memtoreg stays high through ACCESS, so the hazard checker keeps stalling dependents for the whole access.

Decomposition:
- Shared package (pipeline_pkg):
  - opcode constants: OP_IMME_ARITHMETIC, OP_ARITHMETIC, OP_CONDITIONAL_JMP, OP_UNCONDITIONAL_JMP, OP_MEMORY_LOAD, OP_MEMORY_STORE
  - FSM state encoding (IDLE=1'b0, ACCESS=1'b1)
  - XLEN and REG_AW defaults.
- One sub-module, dmem_handshake: owns the req/ack FSM, timeout counter and mem_error. It provides busy, done and abort to the register logic in the top level.

Test Plan:
1. ALU op: ex_rd=5, ex_regwrite=1, ex_alu_result=0x0000_1234 → EX_MEM_rd=5 after edge 1; MEM_WB_result=0x1234, MEM_WB_regwrite=1 after edge 2; dmem_req stays 0.
2. Load: ex_rd=7, ex_memtoreg=1, addr 0x100; ack after 3 wait cycles with dmem_rdata=0xDEADBEEF → dmem_req=1 and dmem_addr=0x100 stable; mem_busy=1 for 3 cycles; then MEM_WB_rd=7, MEM_WB_result=0xDEADBEEF, MEM_WB_regwrite=1; MEM_WB_regwrite=0 during the wait.
3. Stall bubble: ex_stall=1 with ex_rd=9, ex_regwrite=1 → EX_MEM_regwrite=0, EX_MEM_rd=0; next cycle MEM_WB_regwrite=0.
4. x0 write: ex_rd=0, ex_regwrite=1, result 0xFFFF_FFFF → EX_MEM_regwrite=0 and MEM_WB_regwrite=0.
5. Timeout: MEM_TIMEOUT=4, store with no ack → dmem_req high for 4 cycles then low; mem_error=1 and stays 1; next ALU op completes normally.
6. Reset mid-access: assert rst_n=0 during ACCESS → all outputs 0 immediately; a late dmem_ack after release produces no MEM_WB_regwrite.
